// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO UART/counter block.
//   - Register offsets as seen on req_addr (ALU_out[7:0]).
//   - Bit positions inside the control (0x00) and status (0x0C) words.
package mmio_pkg;

    localparam logic [7:0] MMIO_UART_CTRL = 8'h00;  // R : FIFO state bits
    localparam logic [7:0] MMIO_UART_RX   = 8'h04;  // R : pop RX FIFO
    localparam logic [7:0] MMIO_UART_TX   = 8'h08;  // W : push TX FIFO
    localparam logic [7:0] MMIO_STATUS    = 8'h0C;  // RW: overflow flags, counts
    localparam logic [7:0] MMIO_CYC_CNT   = 8'h10;  // R : cycle counter
    localparam logic [7:0] MMIO_INST_CNT  = 8'h14;  // R : instruction counter
    localparam logic [7:0] MMIO_CNT_RST   = 8'h18;  // W : zero both counters

    // Control word bits
    localparam int CTRL_TX_NOT_FULL  = 0;
    localparam int CTRL_RX_NOT_EMPTY = 1;

    // Status word bits / fields
    localparam int ST_TX_OVF    = 0;
    localparam int ST_RX_OVF    = 1;
    localparam int ST_RX_CNT_LO = 8;
    localparam int ST_TX_CNT_LO = 16;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
//   clk, rst    : clock, synchronous active-high reset (pointers/count only)
//   push, wdata : write strobe and data; caller guarantees room (or a
//                 simultaneous pop when full)
//   pop         : read strobe; caller guarantees not empty
//   rdata       : current head entry (combinational)
//   full, empty : occupancy flags
//   count       : number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    // Storage carries data only, so it is not reset. On a full push+pop the
    // write lands on the slot being popped, whose head value is already
    // consumed this cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mmio_uart_ctrl.sv
// mmio_uart_ctrl: memory-mapped UART FIFOs and performance counters.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/we/addr : CPU access (already decoded by addr[31]), store/load,
//   req_wdata           byte offset and store data
//   rdata, rdata_valid: registered load response, one cycle after request
//   inst_retired      : retire pulse for the instruction counter
//   tx_data/valid/ready : TX FIFO head towards the UART transmitter
//   rx_data/valid/ready : bytes from the UART receiver (never stalled)
module mmio_uart_ctrl
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [7:0]        req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    input  logic              inst_retired,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              rd_p0;
    logic              wr_p0;
    logic              wr_tx_p0;
    logic              wr_status_p0;
    logic              wr_cnt_rst_p0;
    logic              rd_rx_p0;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [CW-1:0]     tx_count;

    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CW-1:0]     rx_count;
    logic [DATA_W-1:0] rx_head;

    logic              tx_ovf_q;
    logic              rx_ovf_q;
    logic              tx_ovf_set;
    logic              rx_ovf_set;

    logic [CNT_W-1:0]  cyc_cnt_q;
    logic [CNT_W-1:0]  inst_cnt_q;

    logic [31:0]       rd_mux_p0;
    logic [31:0]       rdata_p1;
    logic              vld_p1;

    // Store data above the UART byte only matters for the W1C bits.
    logic              unused_wdata;
    assign unused_wdata = ^req_wdata[31:DATA_W];

    // ---- Stage p0: request decode, FIFO handshakes, read mux ----
    assign rd_p0         = req_valid && !req_we;
    assign wr_p0         = req_valid &&  req_we;
    assign wr_tx_p0      = wr_p0 && (req_addr == MMIO_UART_TX);
    assign wr_status_p0  = wr_p0 && (req_addr == MMIO_STATUS);
    assign wr_cnt_rst_p0 = wr_p0 && (req_addr == MMIO_CNT_RST);
    assign rd_rx_p0      = rd_p0 && (req_addr == MMIO_UART_RX);

    // A push into a full FIFO is still accepted when the same edge frees a
    // slot; otherwise it is dropped and recorded as an overflow.
    assign tx_valid   = !tx_empty;
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push    = wr_tx_p0 && (!tx_full || tx_pop);
    assign tx_ovf_set = wr_tx_p0 && !tx_push;

    assign rx_ready   = 1'b1;
    assign rx_pop     = rd_rx_p0 && !rx_empty;
    assign rx_push    = rx_valid && (!rx_full || rx_pop);
    assign rx_ovf_set = rx_valid && !rx_push;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (req_wdata[DATA_W-1:0]),
        .pop   (tx_pop),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_data),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Sticky flags: a set in the same cycle as its W1C clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_set ||
                        (tx_ovf_q && !(wr_status_p0 && req_wdata[ST_TX_OVF]));
            rx_ovf_q <= rx_ovf_set ||
                        (rx_ovf_q && !(wr_status_p0 && req_wdata[ST_RX_OVF]));
        end
    end

    // Counter reset overrides both increments, including a coincident retire.
    always_ff @(posedge clk) begin
        if (rst || wr_cnt_rst_p0) begin
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            cyc_cnt_q  <= cyc_cnt_q + 1'b1;
            inst_cnt_q <= inst_cnt_q + CNT_W'(inst_retired);
        end
    end

    always_comb begin
        rd_mux_p0 = '0;
        if (rd_p0) begin
            case (req_addr)
                MMIO_UART_CTRL: begin
                    rd_mux_p0[CTRL_TX_NOT_FULL]  = !tx_full;
                    rd_mux_p0[CTRL_RX_NOT_EMPTY] = !rx_empty;
                end
                MMIO_UART_RX: begin
                    if (!rx_empty) rd_mux_p0 = 32'(rx_head);
                end
                MMIO_STATUS: begin
                    rd_mux_p0[ST_TX_OVF]                   = tx_ovf_q;
                    rd_mux_p0[ST_RX_OVF]                   = rx_ovf_q;
                    rd_mux_p0[ST_RX_CNT_LO +: 8]           = 8'(rx_count);
                    rd_mux_p0[ST_TX_CNT_LO +: 8]           = 8'(tx_count);
                end
                MMIO_CYC_CNT:  rd_mux_p0 = 32'(cyc_cnt_q);
                MMIO_INST_CNT: rd_mux_p0 = 32'(inst_cnt_q);
                default:       rd_mux_p0 = '0;
            endcase
        end
    end

    // ---- Stage p1: registered load response ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            rdata_p1 <= rd_mux_p0;
            vld_p1   <= rd_p0;
        end
    end

    assign rdata       = rdata_p1;
    assign rdata_valid = vld_p1;

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Scoreboard bench for mmio_uart_ctrl: loads push their expected rdata into
// exp_rd, TX bytes expected on the UART side go into exp_tx; a monitor
// branch pops and compares whenever the DUT presents rdata_valid or a TX
// handshake.
module tb_mmio_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        inst_retired;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_rd [$];
    string       exp_nm [$];
    logic [7:0]  exp_tx [$];

    always #5 clk = ~clk;

    mmio_uart_ctrl #(
        .FIFO_DEPTH (8),
        .DATA_W     (8),
        .CNT_W      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .inst_retired (inst_retired),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] e);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        exp_rd.push_back(e);
        exp_nm.push_back(nm);
        step();
        req_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Hard stop if the flow ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; inst_retired = 1'b0; tx_ready = 1'b0;
        rx_data = '0; rx_valid = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && rdata_valid === 1'b1) begin
                    if (exp_rd.size() == 0) begin
                        chk("unexpected_rdata_valid", 32'(rdata_valid), 32'h0);
                    end else begin
                        chk(exp_nm.pop_front(), rdata, exp_rd.pop_front());
                    end
                end
                if (!rst && tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    if (exp_tx.size() == 0) begin
                        chk("unexpected_tx_byte", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
                    end
                end
            end
        join_none

        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rx_ready", 32'(rx_ready), 32'h1);
        rd("ctrl_after_reset", 8'h00, 32'h1);

        // TX fill with the UART stalled, one overflowing byte
        for (int i = 0; i < 9; i++) wr(8'h08, 32'hFFFF_FF41 + 32'(i));
        chk("tx_valid_full", 32'(tx_valid), 32'h1);
        rd("ctrl_tx_full", 8'h00, 32'h0);
        rd("status_tx_ovf", 8'h0C, 32'h0008_0001);
        for (int i = 0; i < 8; i++) exp_tx.push_back(8'h41 + 8'(i));
        tx_ready = 1'b1;
        repeat (10) step();
        chk("tx_drained_valid", 32'(tx_valid), 32'h0);
        wr(8'h0C, 32'h1);
        rd("status_tx_clr", 8'h0C, 32'h0);

        // TX push while full is accepted if the UART pops in the same cycle
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'h08, 32'h60 + 32'(i));
        for (int i = 0; i < 9; i++) exp_tx.push_back(8'h60 + 8'(i));
        tx_ready = 1'b1;
        wr(8'h08, 32'h68);
        tx_ready = 1'b0;
        rd("status_tx_bypass", 8'h0C, 32'h0008_0000);
        tx_ready = 1'b1;
        repeat (10) step();
        tx_ready = 1'b0;

        // RX basic
        rx_byte(8'h55);
        rx_byte(8'hAA);
        rd("ctrl_rx_nonempty", 8'h00, 32'h3);
        rd("rx_first", 8'h04, 32'h55);
        rd("rx_second", 8'h04, 32'hAA);
        rd("rx_empty_read", 8'h04, 32'h0);
        rd("status_rx_empty", 8'h0C, 32'h0);

        // RX full, pop and push in the same cycle
        for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
        rd("status_rx_full", 8'h0C, 32'h0000_0800);
        rx_valid = 1'b1; rx_data = 8'h77;
        rd("rx_bypass_pop", 8'h04, 32'h10);
        rx_valid = 1'b0;
        rd("status_rx_bypass", 8'h0C, 32'h0000_0800);

        // Overflow, then set-wins-over-clear, then a clean clear
        rx_byte(8'h99);
        rd("status_rx_ovf", 8'h0C, 32'h0000_0802);
        rx_valid = 1'b1; rx_data = 8'h9A;
        wr(8'h0C, 32'h2);
        rx_valid = 1'b0;
        rd("status_set_wins", 8'h0C, 32'h0000_0802);
        wr(8'h0C, 32'h2);
        rd("status_clean_clr", 8'h0C, 32'h0000_0800);
        for (int i = 1; i < 8; i++) rd("rx_drain", 8'h04, 32'h10 + 32'(i));
        rd("rx_drain_last", 8'h04, 32'h77);
        rd("rx_drained_empty", 8'h04, 32'h0);

        // Unmapped and write-only offsets read as zero; stray writes ignored
        wr(8'h40, 32'hFFFF_FFFF);
        rd("unmapped_read", 8'h40, 32'h0);
        rd("tx_wo_read", 8'h08, 32'h0);
        rd("ctrl_after_stray", 8'h00, 32'h1);

        // Counters
        wr(8'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i < 37);
            step();
        end
        inst_retired = 1'b0;
        rd("cycle_100", 8'h10, 32'd100);
        rd("instret_37", 8'h14, 32'd37);
        inst_retired = 1'b1;
        wr(8'h18, 32'h0);
        inst_retired = 1'b0;
        rd("cycle_after_rst0", 8'h10, 32'd0);
        rd("cycle_after_rst1", 8'h10, 32'd1);
        rd("instret_after_rst", 8'h14, 32'd0);

        repeat (4) step();
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
        chk("tx_queue_drained", 32'(exp_tx.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
